// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding and the reset PC and NOP defaults.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect input and decode-side output.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface inst_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_out, pc_out, inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_out, pc_out, inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem read in flight,
// and holds the fetched word for decode. Redirects flush and override everything.
module inst_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;

    logic         inst_valid_q;
    logic         inst_fault_q;
    logic [31:0]  inst_q;
    logic [31:0]  pc_out_q;

    logic         hold_load;
    logic         hold_fault;
    logic [31:0]  hold_inst;
    logic [31:0]  hold_pc;

    logic         fetch_go;
    logic [31:0]  fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_out_q     <= RESET_PC;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            inst_valid_q <= (state_n == S_HOLD);
            if (hold_load) begin
                inst_q       <= hold_inst;
                inst_fault_q <= hold_fault;
                pc_out_q     <= hold_pc;
            end
        end
    end

    // fetch_go means "start fetching fetch_pc"; a misaligned target becomes a
    // faulting held NOP instead of an imem request.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_load  = 1'b0;
        hold_fault = 1'b0;
        hold_inst  = NOP_INST;
        hold_pc    = pc;
        fetch_go   = 1'b0;
        fetch_pc   = pc;

        case (state)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_n = bus.redirect_pc;
                    if (bus.imem_req_ready) begin
                        state_n = S_DROP;
                    end else begin
                        fetch_go = 1'b1;
                        fetch_pc = bus.redirect_pc;
                    end
                end else if (bus.imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_n = bus.redirect_pc;
                    if (bus.imem_rsp_valid) begin
                        fetch_go = 1'b1;
                        fetch_pc = bus.redirect_pc;
                    end else begin
                        state_n = S_DROP;
                    end
                end else if (bus.imem_rsp_valid) begin
                    state_n    = S_HOLD;
                    hold_load  = 1'b1;
                    hold_fault = bus.imem_rsp_err;
                    hold_inst  = bus.imem_rsp_err ? NOP_INST : bus.imem_rsp_data;
                    hold_pc    = pc;
                end
            end
            S_DROP: begin
                if (bus.redirect_valid) begin
                    pc_n = bus.redirect_pc;
                end
                if (bus.imem_rsp_valid) begin
                    fetch_go = 1'b1;
                    fetch_pc = bus.redirect_valid ? bus.redirect_pc : pc;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_n     = bus.redirect_pc;
                    fetch_go = 1'b1;
                    fetch_pc = bus.redirect_pc;
                end else if (bus.inst_ready) begin
                    pc_n     = pc + 32'd4;
                    fetch_go = 1'b1;
                    fetch_pc = pc + 32'd4;
                end
            end
        endcase

        if (fetch_go) begin
            if (pc_misaligned(fetch_pc)) begin
                state_n    = S_HOLD;
                hold_load  = 1'b1;
                hold_fault = 1'b1;
                hold_inst  = NOP_INST;
                hold_pc    = fetch_pc;
            end else begin
                state_n = S_REQ;
            end
        end
    end

    always_comb begin
        bus.imem_req_valid = (state == S_REQ);
        bus.imem_req_addr  = pc;
        bus.inst_valid     = inst_valid_q;
        bus.inst_fault     = inst_fault_q;
        bus.inst_out       = inst_q;
        bus.pc_out         = pc_out_q;
    end

    // Protocol checks on both sides of the stage.
    a_req_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid)
        |=> (bus.imem_req_valid && $stable(bus.imem_req_addr)));

    a_inst_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.inst_valid && !bus.inst_ready && !bus.redirect_valid)
        |=> (bus.inst_valid && $stable({bus.inst_out, bus.pc_out, bus.inst_fault})));

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> (state == S_WAIT || state == S_DROP));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: each task drives one scenario cycle by
// cycle and compares outputs against hand-computed values.
module tb_inst_fetch_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC (32'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [33:0] req_obs;
    logic [66:0] hold_obs;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        tick();
        tick();
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0000}) begin
            mismatched++; $display("[TB] FAIL reset_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0000});
        end
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs[65:0] !== {2'b00, 32'h0000_0013, 32'h8000_0000}) begin
            mismatched++; $display("[TB] FAIL reset_outputs: got %h expected %h", hold_obs[65:0], {2'b00, 32'h0000_0013, 32'h8000_0000});
        end
        rst = 1'b0;
        tick();
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0000}) begin
            mismatched++; $display("[TB] FAIL reset_release_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0000});
        end
    endtask

    task automatic test_basic_fetch;
        logic [31:0] words [3];
        logic [31:0] a;
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h8000_0000 + 32'(4 * i);
            req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
            compared++;
            if (req_obs !== {2'b10, a}) begin
                mismatched++; $display("[TB] FAIL basic_req%0d: got %h expected %h", i, req_obs, {2'b10, a});
            end
            bus.imem_req_ready = 1'b1;
            tick();
            bus.imem_req_ready = 1'b0;
            compared++;
            if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
                mismatched++; $display("[TB] FAIL basic_wait%0d: got %b expected 00", i, {bus.imem_req_valid, bus.inst_valid});
            end
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = words[i];
            tick();
            bus.imem_rsp_valid = 1'b0;
            hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
            compared++;
            if (hold_obs !== {3'b010, words[i], a}) begin
                mismatched++; $display("[TB] FAIL basic_hold%0d: got %h expected %h", i, hold_obs, {3'b010, words[i], a});
            end
            tick();
        end
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_000C}) begin
            mismatched++; $display("[TB] FAIL basic_next_req: got %h expected %h", req_obs, {2'b10, 32'h8000_000C});
        end
    endtask

    task automatic test_stall;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00A0_0513;
        tick();
        bus.imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
            compared++;
            if (hold_obs !== {3'b010, 32'h00A0_0513, 32'h8000_000C}) begin
                mismatched++; $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, hold_obs, {3'b010, 32'h00A0_0513, 32'h8000_000C});
            end
            tick();
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0010}) begin
            mismatched++; $display("[TB] FAIL stall_next_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0010});
        end
    endtask

    task automatic test_redirect_wait;
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        compared++;
        if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL redir_wait_drop: got %b expected 00", {bus.imem_req_valid, bus.inst_valid});
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0100}) begin
            mismatched++; $display("[TB] FAIL redir_wait_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0100});
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_006F;
        tick();
        bus.imem_rsp_valid = 1'b0;
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs !== {3'b010, 32'h0000_006F, 32'h8000_0100}) begin
            mismatched++; $display("[TB] FAIL redir_wait_hold: got %h expected %h", hold_obs, {3'b010, 32'h0000_006F, 32'h8000_0100});
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0104}) begin
            mismatched++; $display("[TB] FAIL redir_wait_next: got %h expected %h", req_obs, {2'b10, 32'h8000_0104});
        end
    endtask

    task automatic test_redirect_accept;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
                mismatched++; $display("[TB] FAIL redir_acc_drop%0d: got %b expected 00", i, {bus.imem_req_valid, bus.inst_valid});
            end
            if (i == 0) tick();
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        bus.imem_rsp_valid = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0200}) begin
            mismatched++; $display("[TB] FAIL redir_acc_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0200});
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0041_0113;
        tick();
        bus.imem_rsp_valid = 1'b0;
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs !== {3'b010, 32'h0041_0113, 32'h8000_0200}) begin
            mismatched++; $display("[TB] FAIL redir_acc_hold: got %h expected %h", hold_obs, {3'b010, 32'h0041_0113, 32'h8000_0200});
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_rsp_err;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0008;
        tick();
        bus.redirect_valid = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_0008}) begin
            mismatched++; $display("[TB] FAIL err_req: got %h expected %h", req_obs, {2'b10, 32'h8000_0008});
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs !== {3'b011, 32'h0000_0013, 32'h8000_0008}) begin
            mismatched++; $display("[TB] FAIL err_hold: got %h expected %h", hold_obs, {3'b011, 32'h0000_0013, 32'h8000_0008});
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h8000_000C}) begin
            mismatched++; $display("[TB] FAIL err_next_req: got %h expected %h", req_obs, {2'b10, 32'h8000_000C});
        end
    endtask

    task automatic test_misaligned_wrap;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
            compared++;
            if (hold_obs !== {3'b011, 32'h0000_0013, 32'h8000_0102}) begin
                mismatched++; $display("[TB] FAIL misal_hold%0d: got %h expected %h", i, hold_obs, {3'b011, 32'h0000_0013, 32'h8000_0102});
            end
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'hFFFF_FFFC}) begin
            mismatched++; $display("[TB] FAIL wrap_req: got %h expected %h", req_obs, {2'b10, 32'hFFFF_FFFC});
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0050_0293;
        tick();
        bus.imem_rsp_valid = 1'b0;
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs !== {3'b010, 32'h0050_0293, 32'hFFFF_FFFC}) begin
            mismatched++; $display("[TB] FAIL wrap_hold: got %h expected %h", hold_obs, {3'b010, 32'h0050_0293, 32'hFFFF_FFFC});
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        req_obs = {bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr};
        compared++;
        if (req_obs !== {2'b10, 32'h0000_0000}) begin
            mismatched++; $display("[TB] FAIL wrap_next_req: got %h expected %h", req_obs, {2'b10, 32'h0000_0000});
        end
    endtask

    task automatic test_misaligned_drop;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0042;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        compared++;
        if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL misal_drop_wait: got %b expected 00", {bus.imem_req_valid, bus.inst_valid});
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        bus.imem_rsp_valid = 1'b0;
        hold_obs = {bus.imem_req_valid, bus.inst_valid, bus.inst_fault, bus.inst_out, bus.pc_out};
        compared++;
        if (hold_obs !== {3'b011, 32'h0000_0013, 32'h0000_0042}) begin
            mismatched++; $display("[TB] FAIL misal_drop_hold: got %h expected %h", hold_obs, {3'b011, 32'h0000_0013, 32'h0000_0042});
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_accept();
        test_rsp_err();
        test_misaligned_wrap();
        test_misaligned_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
